// File: rtl/uartb_tx_arbiter.sv
// Round-robin arbiter sharing the UARTB transmit holding register among N
// byte-stream requesters; grant is held for a whole frame, paced on thre.
module uartb_tx_arbiter #(
  parameter int N         = 4,
  parameter int LOCK_TO   = 4096,
  parameter int BLANK_CYC = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  input  logic           thre,
  output logic           tx_we,
  output logic [7:0]     tx_data,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           lock_abort
);

  localparam int PW = $clog2(N);
  localparam int SW = $clog2(LOCK_TO + 1);
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, GRANT, WRITE, BLANK, WAITE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] owner;
  logic [PW-1:0] owner_inc;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] pick;
  logic [N-1:0]  pick_oh;
  logic          found;
  logic [SW-1:0] stall;
  logic [BW-1:0] blank_cnt;
  logic [7:0]    cap_data;
  logic          cap_last;
  logic          timeout;
  logic          hs;
  logic          release_grant;

  // first valid requester scanning upward from rr_ptr, wrapping mod N
  always_comb begin
    int k;
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req_valid[k]) begin
        found = 1'b1;
        pick  = PW'(k);
      end
    end
    pick_oh[pick] = 1'b1;
  end

  assign owner_inc = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
  assign timeout   = (stall == SW'(LOCK_TO));
  assign hs        = |(req_valid & req_ready);
  assign release_grant =
    (state == GRANT && timeout) ||
    (state == WAITE && thre && cap_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      stall     <= '0;
      blank_cnt <= '0;
      cap_data  <= '0;
      cap_last  <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        grant <= pick_oh;
        owner <= pick;
      end else if (release_grant) begin
        grant  <= '0;
        rr_ptr <= owner_inc;
      end
      // saturates at LOCK_TO; only meaningful while in GRANT
      if (state != GRANT || hs) stall <= '0;
      else if (!timeout)        stall <= stall + SW'(1);
      if (hs) begin
        cap_data <= req_data[{owner, 3'b000} +: 8];
        cap_last <= req_last[owner];
      end
      blank_cnt <= (state == BLANK) ? blank_cnt + BW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (found) state_nxt = GRANT;
      GRANT: begin
        if (timeout) state_nxt = IDLE;
        else if (hs) state_nxt = WRITE;
      end
      WRITE: state_nxt = (BLANK_CYC > 0) ? BLANK : WAITE;
      BLANK: begin
        if (blank_cnt == BW'(BLANK_CYC - 1)) state_nxt = WAITE;
      end
      WAITE: begin
        if (thre) state_nxt = cap_last ? IDLE : GRANT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    tx_we      = 1'b0;
    tx_data    = '0;
    lock_abort = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      GRANT: begin
        if (timeout)   lock_abort = 1'b1;
        else if (thre) req_ready  = grant;
      end
      WRITE: begin
        tx_we   = 1'b1;
        tx_data = cap_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uartb_tx_arbiter.sv
// Bench for uartb_tx_arbiter: a per-cycle vector table for one frame,
// then queue-driven requesters and a thre model for the multi-cycle cases.
module tb_uartb_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           thre = 1'b1;
  logic           tx_we;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic           lock_abort;

  always #5 clk = ~clk;

  uartb_tx_arbiter #(
    .N(N), .LOCK_TO(16), .BLANK_CYC(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .thre(thre), .tx_we(tx_we), .tx_data(tx_data),
    .grant(grant), .busy(busy), .lock_abort(lock_abort)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic [7:0] d;
    logic       t;
    logic [3:0] g;
    logic [3:0] r;
    logic       we;
    logic [7:0] txd;
    logic       b;
    logic       ab;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic [3:0] g;
    int         c;
  } ev_t;

  vec_t       tbl[$];
  ev_t        log_q[$];
  logic [8:0] srcq [N][$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int core_cnt = 0;
  int core_len = 3;
  int inv_bad = 0;
  int abort_n = 0;
  int abort_cyc = 0;
  logic abort_prev = 1'b0;
  logic [3:0] grant_after_abort = '1;
  logic [3:0] s_ready, s_hs;
  logic s_we, s_abort, s_busy, s_thre;

  function automatic vec_t mk(
    logic [3:0] v, logic [3:0] l, logic [7:0] d, logic t,
    logic [3:0] g, logic [3:0] r, logic we, logic [7:0] txd,
    logic b, logic ab);
    vec_t x;
    x.v = v; x.l = l; x.d = d; x.t = t;
    x.g = g; x.r = r; x.we = we; x.txd = txd;
    x.b = b; x.ab = ab;
    return x;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic last,
                      input logic [7:0] b);
    srcq[r].push_back({last, b});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (srcq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_src();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic sample_phase();
    @(negedge clk);
    thre = (core_cnt == 0);
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i] = srcq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    #1;
    s_ready = req_ready;
    s_hs    = req_valid & req_ready;
    s_we    = tx_we;
    s_abort = lock_abort;
    s_busy  = busy;
    s_thre  = thre;
    if (!$onehot0(grant) || (req_ready & ~grant) != 0 ||
        (req_ready != 0 && !busy)) inv_bad++;
    if (abort_prev) grant_after_abort = grant;
    abort_prev = lock_abort;
    if (lock_abort) begin
      abort_n++;
      abort_cyc = cyc;
    end
    if (tx_we) begin
      log_q.push_back('{tx_data, grant, cyc});
      core_cnt = core_len;
    end else if (core_cnt > 0) begin
      core_cnt--;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (s_hs[i]) void'(srcq[i].pop_front());
    cyc++;
  endtask

  task automatic run_until_idle(input int bound, input string name);
    bit done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      sample_phase();
      advance();
      if (all_empty() && !s_busy) done = 1'b1;
    end
    chk({name, ".done"}, 32'(done), 32'd1);
  endtask

  task automatic run_until_log(input int want, input int bound,
                               input string name);
    bit done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      sample_phase();
      advance();
      if (log_q.size() >= want) done = 1'b1;
    end
    chk({name, ".done"}, 32'(done), 32'd1);
  endtask

  task automatic expect_ev(input int idx, input logic [7:0] b,
                           input logic [3:0] g, input string name);
    if (idx < log_q.size()) begin
      chk({name, ".byte"}, 32'(log_q[idx].b), 32'(b));
      chk({name, ".grant"}, 32'(log_q[idx].g), 32'(g));
    end else begin
      chk({name, ".count"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    thre = 1'b1;
    core_cnt = 0;
    clear_src();
    log_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int t0, r, h, viol;
    bit seen;

    // reset state, with all requests raised
    req_valid = '1;
    #12;
    chk("reset.outputs",
        {13'h0, grant, req_ready, tx_we, tx_data, busy, lock_abort},
        32'h0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;

    // single frame 0x48,0x69 from req0, one cycle per row
    tbl.push_back(mk(4'h1, 4'h0, 8'h48, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 8'h48, 1'b0, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h0, 8'h48, 1'b1, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 8'h69, 1'b1, 4'h1, 4'h0, 1'b1, 8'h48, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 8'h69, 1'b0, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 8'h69, 1'b0, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 8'h69, 1'b0, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 8'h69, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 4'h1, 8'h69, 1'b1, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b1, 8'h69, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0));
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      req_valid = tbl[k].v;
      req_last  = tbl[k].l;
      req_data  = {24'h0, tbl[k].d};
      thre      = tbl[k].t;
      #1;
      chk($sformatf("frame.row%0d", k),
          {13'h0, grant, req_ready, tx_we, tx_data, busy, lock_abort},
          {13'h0, tbl[k].g, tbl[k].r, tbl[k].we, tbl[k].txd,
           tbl[k].b, tbl[k].ab});
    end

    // contention: 0,1,2 then a full round starting at 3
    do_reset();
    push(0, 1'b1, 8'hA0);
    push(1, 1'b1, 8'hB1);
    push(2, 1'b1, 8'hC2);
    run_until_idle(200, "rr1");
    expect_ev(0, 8'hA0, 4'b0001, "rr1.e0");
    expect_ev(1, 8'hB1, 4'b0010, "rr1.e1");
    expect_ev(2, 8'hC2, 4'b0100, "rr1.e2");
    log_q.delete();
    push(0, 1'b1, 8'hD0);
    push(1, 1'b1, 8'hD1);
    push(2, 1'b1, 8'hD2);
    push(3, 1'b1, 8'hD3);
    run_until_idle(300, "rr2");
    expect_ev(0, 8'hD3, 4'b1000, "rr2.e0");
    expect_ev(1, 8'hD0, 4'b0001, "rr2.e1");
    expect_ev(2, 8'hD1, 4'b0010, "rr2.e2");
    expect_ev(3, 8'hD2, 4'b0100, "rr2.e3");

    // frame lock: req0 arrives during req1's 3-byte frame
    log_q.delete();
    push(1, 1'b0, 8'h11);
    push(1, 1'b0, 8'h12);
    push(1, 1'b1, 8'h13);
    run_until_log(1, 50, "lock.first");
    push(0, 1'b1, 8'h01);
    run_until_idle(300, "lock");
    expect_ev(0, 8'h11, 4'b0010, "lock.e0");
    expect_ev(1, 8'h12, 4'b0010, "lock.e1");
    expect_ev(2, 8'h13, 4'b0010, "lock.e2");
    expect_ev(3, 8'h01, 4'b0001, "lock.e3");

    // stall timeout: req2 sends a non-last byte and then goes quiet
    log_q.delete();
    abort_n = 0;
    grant_after_abort = '1;
    push(2, 1'b0, 8'h2A);
    run_until_log(1, 50, "stall.first");
    push(3, 1'b1, 8'h3B);
    push(0, 1'b1, 8'h0C);
    run_until_idle(300, "stall");
    expect_ev(0, 8'h2A, 4'b0100, "stall.e0");
    chk("stall.abort_pulses", 32'(abort_n), 32'd1);
    if (log_q.size() > 0)
      chk("stall.abort_delay", 32'(abort_cyc - log_q[0].c), 32'd21);
    chk("stall.grant_after", 32'(grant_after_abort), 32'h0);
    expect_ev(1, 8'h3B, 4'b1000, "stall.e1");
    expect_ev(2, 8'h0C, 4'b0001, "stall.e2");

    // thre pacing: core holds thre low for 200 cycles after a write
    log_q.delete();
    abort_n = 0;
    core_len = 200;
    push(0, 1'b0, 8'h50);
    push(0, 1'b1, 8'h51);
    run_until_log(1, 50, "pace.first");
    core_len = 3;
    t0 = (log_q.size() > 0) ? log_q[0].c : 0;
    r = -1;
    h = -1;
    viol = 0;
    for (int n = 0; n < 400 && h < 0; n++) begin
      sample_phase();
      if (!s_thre && (s_ready != 0 || s_we || s_abort)) viol++;
      if (s_thre && r < 0) r = cyc;
      if (s_hs != 0) h = cyc;
      advance();
    end
    chk("pace.quiet", 32'(viol), 32'd0);
    chk("pace.hold", 32'(r - t0), 32'd201);
    chk("pace.resume", 32'(h - r), 32'd1);
    run_until_idle(100, "pace");
    expect_ev(1, 8'h51, 4'b0001, "pace.e1");
    chk("pace.no_abort", 32'(abort_n), 32'd0);

    // reset asserted while the THR write strobe is high
    log_q.delete();
    push(1, 1'b1, 8'h61);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      sample_phase();
      if (s_we) seen = 1'b1;
      else advance();
    end
    chk("rst.reached_write", 32'(seen), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst.async",
        {13'h0, grant, req_ready, tx_we, tx_data, busy, lock_abort},
        32'h0);
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    clear_src();
    core_cnt = 0;
    log_q.delete();
    @(negedge clk);
    reset = 1'b1;
    push(0, 1'b1, 8'h70);
    push(1, 1'b1, 8'h71);
    run_until_idle(200, "rst.after");
    expect_ev(0, 8'h70, 4'b0001, "rst.e0");
    expect_ev(1, 8'h71, 4'b0010, "rst.e1");

    chk("invariants", 32'(inv_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
